// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: mode encoding, field
// limits and the field-increment rule used by both counters.
package stopwatch_ctrl_pkg;

  localparam int FIELD_W     = 6;
  localparam int DEF_MAX_MIN = 59;
  localparam int DEF_MAX_SEC = 59;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_PAUSE = 2'd1,
    MODE_ADJ   = 2'd2
  } mode_e;

  // The >= (rather than ==) keeps a field bounded even if it ever held an out-of-range value.
  function automatic logic [FIELD_W-1:0] wrap_inc(input logic [FIELD_W-1:0] v,
                                                  input int                 max);
    return (int'(v) >= max) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_mod_counter.sv
// Modulo-(MAX+1) field counter with increment enable, synchronous clear
// and a same-cycle wrap pulse used as the carry into the next field.
module mod_counter
  import stopwatch_ctrl_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_inc,
  input  logic               i_clr,
  output logic [FIELD_W-1:0] o_q,
  output logic               o_wrap
);

  logic [FIELD_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_inc) begin
      r_q <= wrap_inc(r_q, MAX);
    end
  end

  assign o_q    = r_q;
  assign o_wrap = i_inc && !i_clr && (int'(r_q) >= MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Minutes:seconds stopwatch with RUN / PAUSE / ADJ modes; clear has top
// priority and ticks are always judged against the state before the edge.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int MAX_MIN = DEF_MAX_MIN,
  parameter int MAX_SEC = DEF_MAX_SEC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_1hz,
  input  logic               tick_2hz,
  input  logic               pause_p,
  input  logic               clear_p,
  input  logic               adj,
  input  logic               sel,
  output logic [FIELD_W-1:0] minutes,
  output logic [FIELD_W-1:0] seconds,
  output logic               blink_min,
  output logic               blink_sec,
  output logic [1:0]         mode
);

  mode_e r_state;
  mode_e w_state_nxt;
  logic  r_blink_min;
  logic  r_blink_sec;
  logic  w_blink_min_nxt;
  logic  w_blink_sec_nxt;
  logic  w_sec_inc;
  logic  w_min_inc;
  logic  w_sec_wrap;
  logic  w_unused_min_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= MODE_PAUSE;
      r_blink_min <= 1'b0;
      r_blink_sec <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_blink_min <= w_blink_min_nxt;
      r_blink_sec <= w_blink_sec_nxt;
    end
  end

  // Leaving ADJ always lands in PAUSE, so counting only resumes on an explicit press.
  always_comb begin
    w_state_nxt = r_state;
    if (!clear_p) begin
      unique case (r_state)
        MODE_RUN: begin
          if (adj)          w_state_nxt = MODE_ADJ;
          else if (pause_p) w_state_nxt = MODE_PAUSE;
        end
        MODE_PAUSE: begin
          if (adj)          w_state_nxt = MODE_ADJ;
          else if (pause_p) w_state_nxt = MODE_RUN;
        end
        MODE_ADJ: begin
          if (!adj)         w_state_nxt = MODE_PAUSE;
        end
        default:            w_state_nxt = MODE_PAUSE;
      endcase
    end
  end

  always_comb begin
    w_blink_min_nxt = 1'b0;
    w_blink_sec_nxt = 1'b0;
    if (w_state_nxt == MODE_ADJ) begin
      w_blink_min_nxt = !sel;
      w_blink_sec_nxt = sel;
    end
  end

  // Increments use r_state (pre-edge mode); minutes only take a carry in RUN.
  assign w_sec_inc = !clear_p &&
                     (((r_state == MODE_RUN) && tick_1hz) ||
                      ((r_state == MODE_ADJ) && tick_2hz && sel));
  assign w_min_inc = !clear_p &&
                     (((r_state == MODE_RUN) && w_sec_wrap) ||
                      ((r_state == MODE_ADJ) && tick_2hz && !sel));

  mod_counter #(.MAX(MAX_SEC)) u_sec (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_sec_inc),
    .i_clr  (clear_p),
    .o_q    (seconds),
    .o_wrap (w_sec_wrap)
  );

  mod_counter #(.MAX(MAX_MIN)) u_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_inc  (w_min_inc),
    .i_clr  (clear_p),
    .o_q    (minutes),
    .o_wrap (w_unused_min_wrap)
  );

  assign mode      = r_state;
  assign blink_min = r_blink_min;
  assign blink_sec = r_blink_sec;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a total-seconds reference model
// predicts each cycle's outputs, a monitor compares them one clk later.
module tb_stopwatch_ctrl;

  localparam int TMAX_MIN = 59;
  localparam int TMAX_SEC = 59;
  localparam int M_RUN    = 0;
  localparam int M_PAUSE  = 1;
  localparam int M_ADJ    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick_1hz = 1'b0, tick_2hz = 1'b0, pause_p = 1'b0, clear_p = 1'b0;
  logic       adj = 1'b0, sel = 1'b0;
  logic [5:0] minutes, seconds;
  logic       blink_min, blink_sec;
  logic [1:0] mode;

  typedef struct packed {
    logic [5:0] mn;
    logic [5:0] sc;
    logic [1:0] md;
    logic       bm;
    logic       bs;
  } exp_t;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_min = 0, m_sec = 0, m_mode = M_PAUSE;

  stopwatch_ctrl #(.MAX_MIN(TMAX_MIN), .MAX_SEC(TMAX_SEC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick_1hz),
    .tick_2hz  (tick_2hz),
    .pause_p   (pause_p),
    .clear_p   (clear_p),
    .adj       (adj),
    .sel       (sel),
    .minutes   (minutes),
    .seconds   (seconds),
    .blink_min (blink_min),
    .blink_sec (blink_sec),
    .mode      (mode)
  );

  always #5 clk = ~clk;

  // Reference model: time as a single count of seconds, modes from the rules.
  task automatic model_step(input bit t1, input bit t2, input bit p, input bit c,
                            input bit a, input bit s);
    int old;
    int total;
    old = m_mode;
    if (c) begin
      m_min = 0;
      m_sec = 0;
    end else begin
      if (old == M_RUN && t1) begin
        total = (m_min * (TMAX_SEC + 1) + m_sec + 1) % ((TMAX_MIN + 1) * (TMAX_SEC + 1));
        m_min = total / (TMAX_SEC + 1);
        m_sec = total % (TMAX_SEC + 1);
      end else if (old == M_ADJ && t2) begin
        if (s) m_sec = (m_sec + 1) % (TMAX_SEC + 1);
        else   m_min = (m_min + 1) % (TMAX_MIN + 1);
      end
      if (old != M_ADJ && a)       m_mode = M_ADJ;
      else if (old == M_ADJ && !a) m_mode = M_PAUSE;
      else if (old != M_ADJ && p)  m_mode = (old == M_RUN) ? M_PAUSE : M_RUN;
    end
  endtask

  task automatic apply(input bit t1, input bit t2, input bit p, input bit c,
                       input bit a, input bit s);
    exp_t e;
    tick_1hz = t1; tick_2hz = t2; pause_p = p; clear_p = c; adj = a; sel = s;
    model_step(t1, t2, p, c, a, s);
    e.mn = 6'(m_min);
    e.sc = 6'(m_sec);
    e.md = 2'(m_mode);
    e.bm = (m_mode == M_ADJ) && !s;
    e.bs = (m_mode == M_ADJ) && s;
    q_exp.push_back(e);
  endtask

  task automatic cyc(input bit t1, input bit t2, input bit p, input bit c,
                     input bit a, input bit s);
    @(negedge clk);
    apply(t1, t2, p, c, a, s);
  endtask

  task automatic expect_state(input string nm, input int mn, input int sc, input int md,
                              input bit bm, input bit bs);
    @(posedge clk);
    #2;
    n_checks++;
    if (minutes !== 6'(mn) || seconds !== 6'(sc) || mode !== 2'(md) ||
        blink_min !== bm || blink_sec !== bs) begin
      n_errors++;
      $display("FAIL %s: got %0d:%0d mode=%0d bm=%0b bs=%0b, want %0d:%0d mode=%0d bm=%0b bs=%0b",
               nm, minutes, seconds, mode, blink_min, blink_sec, mn, sc, md, bm, bs);
    end
  endtask

  // Asserts reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    tick_1hz = 1'b0; tick_2hz = 1'b0; pause_p = 1'b0; clear_p = 1'b0; adj = 1'b0; sel = 1'b0;
    #1;
    n_checks++;
    if (minutes !== 6'd0 || seconds !== 6'd0 || mode !== 2'd1 ||
        blink_min !== 1'b0 || blink_sec !== 1'b0) begin
      n_errors++;
      $display("FAIL %s async: got %0d:%0d mode=%0d bm=%0b bs=%0b, want 0:0 mode=1 bm=0 bs=0",
               nm, minutes, seconds, mode, blink_min, blink_sec);
    end
    repeat (2) @(negedge clk);
    m_min = 0; m_sec = 0; m_mode = M_PAUSE;
    rst_n = 1'b1;
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_state({nm, "_release"}, 0, 0, M_PAUSE, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        n_checks++;
        if ({minutes, seconds, mode, blink_min, blink_sec} !== e) begin
          n_errors++;
          $display("FAIL scoreboard t=%0t: got %0d:%0d mode=%0d bm=%0b bs=%0b, want %0d:%0d mode=%0d bm=%0b bs=%0b",
                   $time, minutes, seconds, mode, blink_min, blink_sec,
                   e.mn, e.sc, e.md, e.bm, e.bs);
        end
      end
    end
  end

  initial begin : stimulus
    bit r_a, r_s;
    #2;
    do_reset("por");

    cyc(0, 0, 1, 0, 0, 0);
    repeat (61) cyc(1, 0, 0, 0, 0, 0);
    expect_state("run_61_ticks", 1, 1, M_RUN, 1'b0, 1'b0);

    cyc(0, 0, 0, 0, 1, 1);
    repeat (58) cyc(0, 1, 0, 0, 1, 1);
    repeat (58) cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    expect_state("at_59_59", 59, 59, M_RUN, 1'b0, 1'b0);
    cyc(1, 0, 0, 0, 0, 0);
    expect_state("full_wrap", 0, 0, M_RUN, 1'b0, 1'b0);

    repeat (10) cyc(1, 0, 0, 0, 0, 0);
    expect_state("run_00_10", 0, 10, M_RUN, 1'b0, 1'b0);
    cyc(0, 0, 0, 0, 1, 1);
    repeat (55) cyc(0, 1, 0, 0, 1, 1);
    expect_state("adj_sec_wrap", 0, 5, M_ADJ, 1'b0, 1'b1);
    cyc(0, 0, 0, 0, 1, 0);
    repeat (3) cyc(0, 1, 0, 0, 1, 0);
    expect_state("adj_min", 3, 5, M_ADJ, 1'b1, 1'b0);

    repeat (20) cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 1, 0);
    expect_state("adj_ignores_1hz_pause", 3, 5, M_ADJ, 1'b1, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_state("adj_exit_pause", 3, 5, M_PAUSE, 1'b0, 1'b0);
    cyc(0, 0, 1, 0, 0, 0);
    expect_state("resume", 3, 5, M_RUN, 1'b0, 1'b0);

    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    repeat (12) cyc(0, 1, 0, 0, 1, 0);
    repeat (34) cyc(0, 1, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    expect_state("run_12_34", 12, 34, M_RUN, 1'b0, 1'b0);
    cyc(1, 0, 1, 1, 0, 0);
    expect_state("clear_priority", 0, 0, M_RUN, 1'b0, 1'b0);

    cyc(0, 0, 0, 0, 1, 0);
    repeat (7) cyc(0, 1, 0, 0, 1, 0);
    repeat (42) cyc(0, 1, 0, 0, 1, 1);
    expect_state("adj_07_42", 7, 42, M_ADJ, 1'b0, 1'b1);
    do_reset("mid_adj_reset");

    r_a = 1'b0;
    r_s = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) r_a = !r_a;
      if ($urandom_range(5) == 0)  r_s = !r_s;
      cyc($urandom_range(2) == 0, $urandom_range(2) == 0, $urandom_range(11) == 0,
          $urandom_range(79) == 0, r_a, r_s);
      if (i == 1500) begin
        @(posedge clk);
        #2;
        do_reset("random_reset");
        r_a = 1'b0;
      end
    end
    @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: MAX_MIN, 59, highest minutes value before wrap to 0.
REQ-002 Parameter: MAX_SEC, 59, highest seconds value before wrap to 0.
REQ-003 Port: clk  in  1  single system clock; all state updates on posedge clk.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: tick_1hz  in  1  one-clk-wide count enable, 1 Hz.
REQ-006 Port: tick_2hz  in  1  one-clk-wide adjust enable, 2 Hz.
REQ-007 Port: pause_p  in  1  one-clk-wide debounced pause/resume press.
REQ-008 Port: clear_p  in  1  one-clk-wide debounced clear press.
REQ-009 Port: adj  in  1  level; 1 = adjust mode requested.
REQ-010 Port: sel  in  1  level; 1 = adjust seconds, 0 = adjust minutes.
REQ-011 Port: minutes  out  6  current minutes, 0..MAX_MIN.
REQ-012 Port: seconds  out  6  current seconds, 0..MAX_SEC.
REQ-013 Port: blink_min  out  1  1 when minutes is the field being adjusted.
REQ-014 Port: blink_sec  out  1  1 when seconds is the field being adjusted.
REQ-015 Port: mode  out  2  state code: 0 RUN, 1 PAUSE, 2 ADJ.

Function
REQ-016 States SHALL be RUN, PAUSE and ADJ; all outputs SHALL be registered.
REQ-017 RUN: on tick_1hz, seconds SHALL increment; at MAX_SEC, seconds SHALL go to 0 and minutes SHALL increment.
REQ-018 RUN: at MAX_MIN:MAX_SEC, a tick_1hz SHALL wrap both fields to 00:00 with no flag.
REQ-019 RUN -> PAUSE on pause_p; PAUSE -> RUN on pause_p.
REQ-020 PAUSE: minutes and seconds SHALL hold; tick_1hz SHALL be ignored.
REQ-021 From RUN or PAUSE, adj=1 SHALL enter ADJ on the next clk.
REQ-022 ADJ -> PAUSE when adj falls; the stopwatch SHALL never resume counting without a pause_p.
REQ-023 ADJ: tick_1hz SHALL be ignored; on tick_2hz the field chosen by sel SHALL increment by 1.
REQ-024 ADJ wrap: the selected field SHALL wrap MAX->0, with no carry into the other field.
REQ-025 ADJ: sel SHALL be sampled each clk; a sel change SHALL take effect on the next tick_2hz.
REQ-026 blink_sec SHALL equal (mode==ADJ && sel); blink_min SHALL equal (mode==ADJ && !sel); both SHALL be 0 outside ADJ.
REQ-027 clear_p in any state SHALL set both fields to 0 on the next clk and SHALL leave the state unchanged.
REQ-028 Priority in one cycle: clear_p > adj-driven mode change > pause_p > tick increment.
REQ-029 A tick coinciding with a state change SHALL be evaluated under the old state.
REQ-030 pause_p SHALL be ignored while in ADJ.
REQ-031 Latency: every input event SHALL be visible on the outputs exactly one clk later.
REQ-032 Field values SHALL never exceed their MAX, under any input sequence.

Reset
REQ-033 When rst_n is low: minutes=0, seconds=0, mode=PAUSE, blink_min=0, blink_sec=0, asynchronously.
REQ-034 Deassertion SHALL take effect at the next posedge clk; a tick in that same cycle SHALL be ignored.
REQ-035 Reset mid-adjust SHALL discard the adjusted values.

Structure
REQ-036 A shared package SHALL hold the mode encoding (RUN/PAUSE/ADJ) and the MAX_MIN/MAX_SEC defaults.
REQ-037 One sub-module, mod_counter (6-bit, parameterised MAX, inc enable, clear, wrap-out pulse), SHALL be instantiated twice, once per field.
REQ-038 No derived or gated clocks are allowed; tick_1hz and tick_2hz are clock enables only.

Verification
REQ-039 Reset release, then pause_p, then 61 tick_1hz -> mode=RUN, 01:01.
REQ-040 From 59:59 in RUN, one tick_1hz -> 00:00.
REQ-041 In RUN at 00:10, set adj=1 and sel=1, then 55 tick_2hz -> 00:05 with blink_sec=1; set sel=0, then 3 tick_2hz -> 03:05 with blink_min=1.
REQ-042 In ADJ, tick_1hz stream -> no change; adj=0 -> mode=PAUSE; pause_p -> mode=RUN.
REQ-043 clear_p, tick_1hz and pause_p in the same cycle in RUN at 12:34 -> 00:00, mode=RUN.
REQ-044 rst_n pulsed low mid-ADJ at 07:42 -> 00:00 immediately, mode=PAUSE, blink outputs=0.
